// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture_buffer
// Purpose  : Multi-channel NoC debug trace recorder. Round-robin arbitration
//            of NUM_CH trace sources into one circular RAM, with arm/trigger
//            control, programmable post-trigger length and oldest-first
//            readout once capture has frozen.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            ch_valid/ch_data - per-channel trace words (no backpressure)
//            ch_mask          - per-channel capture enable
//            arm, trigger     - single-cycle control pulses
//            post_len         - post-trigger entry count, sampled on trigger
//            rd_en            - pop one entry (DONE only)
//            rd_data/rd_valid - {ts, ch_id, data}, valid one cycle after rd_en
//            rd_empty         - no unread entries
//            state            - IDLE=0, ARMED=1, POST=2, DONE=3
//            fill_cnt         - stored, unread entries
//            wrapped          - write pointer wrapped during this capture
//            trig_addr        - RAM address written in the trigger cycle
//            drop_cnt         - saturating count of words lost to arbitration
// Revision : 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 512,
  parameter int TS_W    = 16,
  parameter int DROP_W  = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int ENTRY_W = TS_W + CH_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [ADDR_W-1:0]        post_len,
  input  logic                     rd_en,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     rd_valid,
  output logic                     rd_empty,
  output logic [1:0]               state,
  output logic [ADDR_W:0]          fill_cnt,
  output logic                     wrapped,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int SUM_W = DROP_W + CNT_W;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [TS_W-1:0]    r_ts;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W-1:0]  r_remaining;
  logic [ADDR_W-1:0]  r_trig_addr;
  logic [ADDR_W:0]    r_fill_cnt;
  logic               r_wrapped;
  logic [DROP_W-1:0]  r_drop_cnt;
  logic [CH_W-1:0]    r_last_grant;
  logic [ENTRY_W-1:0] r_rd_data;
  logic               r_rd_valid;
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic [NUM_CH-1:0]  w_elig;
  logic               w_grant_vld;
  logic [CH_W-1:0]    w_grant_id;
  logic [DATA_W-1:0]  w_grant_data;
  logic [CNT_W-1:0]   w_n_elig;
  logic [CNT_W-1:0]   w_n_drop;
  logic [SUM_W-1:0]   w_drop_sum;
  logic [DROP_W-1:0]  w_drop_sat;
  logic               w_capture;
  logic               w_we;
  logic               w_trig_take;
  logic               w_rd_ok;
  logic [ADDR_W-1:0]  w_wr_ptr_nxt;
  logic               w_wrapped_nxt;

  // --------------------------------------------------------------------------
  // Round-robin arbiter: scan starting one past the last granted channel.
  // --------------------------------------------------------------------------
  assign w_elig = ch_valid & ch_mask;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!w_grant_vld && w_elig[(int'(r_last_grant) + k) % NUM_CH]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = CH_W'((int'(r_last_grant) + k) % NUM_CH);
      end
    end
  end

  assign w_grant_data = ch_data[w_grant_id*DATA_W +: DATA_W];

  // Every eligible channel except the granted one loses its word.
  always_comb begin
    w_n_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_n_elig = w_n_elig + CNT_W'(w_elig[i]);
    end
  end

  assign w_n_drop   = w_grant_vld ? (w_n_elig - CNT_W'(1)) : '0;
  assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_n_drop);
  assign w_drop_sat = (|w_drop_sum[SUM_W-1:DROP_W]) ? '1 : w_drop_sum[DROP_W-1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. arm always wins over trigger.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (arm)          w_state_nxt = S_ARMED;
        else if (trigger) w_state_nxt = (post_len == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (arm) w_state_nxt = S_ARMED;
        else if (w_we && r_remaining == ADDR_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / control decode. The arm cycle itself neither writes,
  // counts drops nor reads; its clears take precedence.
  // --------------------------------------------------------------------------
  always_comb begin
    w_capture   = ((r_state == S_ARMED) || (r_state == S_POST)) && !arm;
    w_we        = w_capture && w_grant_vld;
    w_trig_take = (r_state == S_ARMED) && !arm && trigger;
    w_rd_ok     = (r_state == S_DONE) && !arm && rd_en && (r_fill_cnt != '0);
  end

  assign w_wr_ptr_nxt  = w_we ? (r_wr_ptr + ADDR_W'(1)) : r_wr_ptr;
  assign w_wrapped_nxt = r_wrapped | (w_we && (r_wr_ptr == ADDR_W'(DEPTH - 1)));

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts         <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_remaining  <= '0;
      r_trig_addr  <= '0;
      r_fill_cnt   <= '0;
      r_wrapped    <= 1'b0;
      r_drop_cnt   <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_ts       <= r_ts + TS_W'(1);
      r_rd_valid <= 1'b0;
      if (arm) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fill_cnt <= '0;
        r_wrapped  <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        if (w_capture) begin
          r_drop_cnt <= w_drop_sat;
          r_wr_ptr   <= w_wr_ptr_nxt;
          r_wrapped  <= w_wrapped_nxt;
          if (w_we) begin
            r_last_grant <= w_grant_id;
            if (r_fill_cnt != (ADDR_W+1)'(DEPTH)) begin
              r_fill_cnt <= r_fill_cnt + (ADDR_W+1)'(1);
            end
          end
        end
        // post_len is ADDR_W wide, so it can never exceed DEPTH-1 and needs
        // no explicit clamp.
        if (w_trig_take) begin
          r_trig_addr <= r_wr_ptr;
          r_remaining <= post_len;
        end else if ((r_state == S_POST) && w_we) begin
          r_remaining <= r_remaining - ADDR_W'(1);
        end
        // On DONE entry point the read pointer at the oldest surviving entry.
        if ((r_state != S_DONE) && (w_state_nxt == S_DONE)) begin
          r_rd_ptr <= w_wrapped_nxt ? w_wr_ptr_nxt : '0;
        end
        if (w_rd_ok) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
          r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
          r_fill_cnt <= r_fill_cnt - (ADDR_W+1)'(1);
        end
      end
    end
  end

  // Trace RAM (contents are not reset)
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= {r_ts, w_grant_id, w_grant_data};
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign rd_empty  = (r_fill_cnt == '0);
  assign state     = r_state;
  assign fill_cnt  = r_fill_cnt;
  assign wrapped   = r_wrapped;
  assign trig_addr = r_trig_addr;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
